// File: rtl/ray_dispatcher.sv
// Ray dispatcher: accepts one ray request at a time, launches the triangle
// intersector, waits for its finish level under a watchdog, then returns
// the hit result on a valid/ready channel.
module ray_dispatcher #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777215
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [191:0]       i_req_ray,
  input  logic [15:0]        i_req_id,
  input  logic [31:0]        i_req_baseaddr,
  input  logic [31:0]        i_req_tri_cnt,
  output logic               ins_ivalid,
  output logic [191:0]       ins_ray,
  output logic [31:0]        ins_baseaddr,
  output logic [31:0]        ins_tri_cnt,
  input  logic               ins_hit,
  input  logic signed [31:0] ins_t,
  input  logic [31:0]        ins_tri_index,
  input  logic               ins_finish,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [15:0]        o_res_id,
  output logic               o_res_hit,
  output logic signed [31:0] o_res_t,
  output logic [31:0]        o_res_tri_index,
  output logic               o_busy,
  output logic               o_error,
  output logic [31:0]        o_ray_count
);

  localparam int unsigned WD_W = 32;
  localparam logic [WD_W-1:0] WD_LAST = TIMEOUT_CYCLES - WD_W'(1);
  localparam logic signed [31:0] T_MISS = 32'sh7fffffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd_cnt;

  // Dispatcher FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wd_cnt          <= '0;
      o_req_ready     <= 1'b1;
      ins_ivalid      <= 1'b0;
      ins_ray         <= '0;
      ins_baseaddr    <= '0;
      ins_tri_cnt     <= '0;
      o_res_valid     <= 1'b0;
      o_res_id        <= '0;
      o_res_hit       <= 1'b0;
      o_res_t         <= '0;
      o_res_tri_index <= '0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
      o_ray_count     <= '0;
    end else begin
      ins_ivalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            ins_ray      <= i_req_ray;
            ins_baseaddr <= i_req_baseaddr;
            ins_tri_cnt  <= i_req_tri_cnt;
            o_res_id     <= i_req_id;
            o_req_ready  <= 1'b0;
            o_busy       <= 1'b1;
            if (i_req_tri_cnt != 32'd0) begin
              state      <= S_LAUNCH;
              ins_ivalid <= 1'b1;
            end else begin
              // Empty triangle list: report a miss without touching the intersector
              state           <= S_RESULT;
              o_res_valid     <= 1'b1;
              o_res_hit       <= 1'b0;
              o_res_t         <= T_MISS;
              o_res_tri_index <= '0;
            end
          end
        end
        S_LAUNCH: begin
          state <= S_ARM;
        end
        S_ARM: begin
          // Intersector finish may still read 1 here; skip it
          state  <= S_WAIT;
          wd_cnt <= '0;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (ins_finish) begin
            state           <= S_RESULT;
            o_res_valid     <= 1'b1;
            o_res_hit       <= ins_hit;
            o_res_t         <= ins_t;
            o_res_tri_index <= ins_tri_index;
          end else if ((TIMEOUT_CYCLES != 32'd0) && (wd_cnt == WD_LAST)) begin
            state   <= S_ERROR;
            o_error <= 1'b1;
          end
        end
        S_RESULT: begin
          if (i_res_ready) begin
            state       <= S_IDLE;
            o_res_valid <= 1'b0;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_ray_count <= o_ray_count + 32'd1;
          end
        end
        S_ERROR: begin
          // Sticky until reset
          o_error     <= 1'b1;
          o_req_ready <= 1'b0;
          o_res_valid <= 1'b0;
          o_busy      <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_res_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher: instance A uses the default watchdog,
// instance B uses an 8-cycle watchdog for the timeout scenarios.
module tb_ray_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [191:0] RAY1 = {32'h00000000, 32'h00000000, 32'h00010000,
                                   32'h00030000, 32'h00020000, 32'h00010000};

  // Instance A signals
  logic a_reset, a_req_valid, a_req_ready, a_ivalid, a_hit_in, a_finish;
  logic a_res_valid, a_res_ready, a_res_hit, a_busy, a_error;
  logic [191:0] a_req_ray, a_ins_ray;
  logic [15:0]  a_req_id, a_res_id;
  logic [31:0]  a_req_base, a_req_tri, a_ins_base, a_ins_tri, a_idx_in, a_res_idx, a_count;
  logic signed [31:0] a_t_in, a_res_t;

  // Instance B signals
  logic b_reset, b_req_valid, b_req_ready, b_ivalid, b_hit_in, b_finish;
  logic b_res_valid, b_res_ready, b_res_hit, b_busy, b_error;
  logic [191:0] b_req_ray, b_ins_ray;
  logic [15:0]  b_req_id, b_res_id;
  logic [31:0]  b_req_base, b_req_tri, b_ins_base, b_ins_tri, b_idx_in, b_res_idx, b_count;
  logic signed [31:0] b_t_in, b_res_t;

  ray_dispatcher dut_a (
    .clk(clk), .reset(a_reset),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
    .i_req_ray(a_req_ray), .i_req_id(a_req_id),
    .i_req_baseaddr(a_req_base), .i_req_tri_cnt(a_req_tri),
    .ins_ivalid(a_ivalid), .ins_ray(a_ins_ray),
    .ins_baseaddr(a_ins_base), .ins_tri_cnt(a_ins_tri),
    .ins_hit(a_hit_in), .ins_t(a_t_in), .ins_tri_index(a_idx_in), .ins_finish(a_finish),
    .o_res_valid(a_res_valid), .i_res_ready(a_res_ready), .o_res_id(a_res_id),
    .o_res_hit(a_res_hit), .o_res_t(a_res_t), .o_res_tri_index(a_res_idx),
    .o_busy(a_busy), .o_error(a_error), .o_ray_count(a_count)
  );

  ray_dispatcher #(.TIMEOUT_CYCLES(32'd8)) dut_b (
    .clk(clk), .reset(b_reset),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
    .i_req_ray(b_req_ray), .i_req_id(b_req_id),
    .i_req_baseaddr(b_req_base), .i_req_tri_cnt(b_req_tri),
    .ins_ivalid(b_ivalid), .ins_ray(b_ins_ray),
    .ins_baseaddr(b_ins_base), .ins_tri_cnt(b_ins_tri),
    .ins_hit(b_hit_in), .ins_t(b_t_in), .ins_tri_index(b_idx_in), .ins_finish(b_finish),
    .o_res_valid(b_res_valid), .i_res_ready(b_res_ready), .o_res_id(b_res_id),
    .o_res_hit(b_res_hit), .o_res_t(b_res_t), .o_res_tri_index(b_res_idx),
    .o_busy(b_busy), .o_error(b_error), .o_ray_count(b_count)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", a_req_ready); end
    n_tests++;
    if ({a_ivalid, a_res_valid, a_res_hit, a_busy, a_error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 00000", {a_ivalid, a_res_valid, a_res_hit, a_busy, a_error});
    end
    n_tests++;
    if ({a_res_id, a_res_t, a_res_idx, a_count} !== 112'd0) begin
      n_fail++; $display("FAIL reset_result: got id=%h t=%h idx=%h cnt=%h exp 0", a_res_id, a_res_t, a_res_idx, a_count);
    end
    n_tests++;
    if ({a_ins_ray, a_ins_base, a_ins_tri} !== 256'd0) begin
      n_fail++; $display("FAIL reset_ins_regs: got base=%h tri=%h exp 0", a_ins_base, a_ins_tri);
    end
  endtask

  task automatic test_single_ray();
    int pulses;
    int early;
    a_req_ray = RAY1; a_req_id = 16'h0005; a_req_base = 32'h0000_1000; a_req_tri = 32'd3;
    a_req_valid = 1'b1; a_res_ready = 1'b0;
    tick();
    a_req_valid = 1'b0;
    n_tests++;
    if ({a_ivalid, a_busy, a_req_ready} !== 3'b110) begin
      n_fail++; $display("FAIL single_launch: got ivalid/busy/ready=%b exp 110", {a_ivalid, a_busy, a_req_ready});
    end
    n_tests++;
    if (a_ins_ray !== RAY1 || a_ins_base !== 32'h1000 || a_ins_tri !== 32'd3) begin
      n_fail++; $display("FAIL single_ins_fields: got base=%h tri=%h exp 1000 3", a_ins_base, a_ins_tri);
    end
    pulses = 1; early = 0;
    a_finish = 1'b0;
    a_req_ray = ~RAY1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (a_ivalid) pulses++;
      if (a_res_valid) early++;
    end
    a_hit_in = 1'b1; a_t_in = 32'sh00018000; a_idx_in = 32'd2; a_finish = 1'b1;
    tick();
    n_tests++;
    if (pulses !== 1 || early !== 0) begin
      n_fail++; $display("FAIL single_pulses: got pulses=%0d early=%0d exp 1 0", pulses, early);
    end
    n_tests++;
    if (a_ins_ray !== RAY1) begin n_fail++; $display("FAIL single_ray_hold: got %h exp %h", a_ins_ray, RAY1); end
    n_tests++;
    if ({a_res_valid, a_res_hit} !== 2'b11 || a_res_id !== 16'h5 || a_res_t !== 32'sh00018000 || a_res_idx !== 32'd2) begin
      n_fail++; $display("FAIL single_result: got v=%b hit=%b id=%h t=%h idx=%h exp 1 1 5 18000 2",
                         a_res_valid, a_res_hit, a_res_id, a_res_t, a_res_idx);
    end
    a_t_in = 32'sh0000dead;
    tick();
    n_tests++;
    if (a_res_t !== 32'sh00018000 || a_res_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_hold: got t=%h v=%b exp 18000 1", a_res_t, a_res_valid);
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if ({a_res_valid, a_req_ready, a_busy} !== 3'b010 || a_count !== 32'd1) begin
      n_fail++; $display("FAIL single_done: got v/rdy/busy=%b cnt=%0d exp 010 1", {a_res_valid, a_req_ready, a_busy}, a_count);
    end
  endtask

  task automatic test_zero_tri();
    a_req_id = 16'h0007; a_req_tri = 32'd0; a_req_valid = 1'b1; a_hit_in = 1'b1;
    tick();
    a_req_valid = 1'b0;
    n_tests++;
    if ({a_res_valid, a_ivalid, a_res_hit} !== 3'b100 || a_res_t !== 32'sh7fffffff || a_res_idx !== 32'd0 || a_res_id !== 16'h7) begin
      n_fail++; $display("FAIL zero_result: got v=%b iv=%b hit=%b t=%h idx=%h id=%h exp 1 0 0 7fffffff 0 7",
                         a_res_valid, a_ivalid, a_res_hit, a_res_t, a_res_idx, a_res_id);
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if (a_count !== 32'd2 || a_ivalid !== 1'b0 || a_res_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got cnt=%0d iv=%b v=%b exp 2 0 0", a_count, a_ivalid, a_res_valid);
    end
  endtask

  task automatic test_stale_finish();
    a_finish = 1'b1; a_hit_in = 1'b1; a_t_in = 32'sh11111111; a_idx_in = 32'd9;
    a_req_id = 16'h0003; a_req_tri = 32'd5; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    n_tests++;
    if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL stale_arm: got v=%b exp 0", a_res_valid); end
    tick();
    n_tests++;
    if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL stale_wait_entry: got v=%b exp 0", a_res_valid); end
    a_hit_in = 1'b0; a_t_in = 32'sh22222222; a_idx_in = 32'd4;
    tick();
    n_tests++;
    if ({a_res_valid, a_res_hit} !== 2'b10 || a_res_t !== 32'sh22222222 || a_res_idx !== 32'd4 || a_res_id !== 16'h3) begin
      n_fail++; $display("FAIL stale_result: got v=%b hit=%b t=%h idx=%h id=%h exp 1 0 22222222 4 3",
                         a_res_valid, a_res_hit, a_res_t, a_res_idx, a_res_id);
    end
  endtask

  task automatic test_back_to_back();
    a_req_id = 16'h0009; a_req_tri = 32'd1; a_req_valid = 1'b1; a_res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_t_in = 32'(i);
      a_hit_in = i[0];
      tick();
      n_tests++;
      if (a_res_valid !== 1'b1 || a_req_ready !== 1'b0 || a_ivalid !== 1'b0 ||
          a_res_t !== 32'sh22222222 || a_res_hit !== 1'b0 || a_res_idx !== 32'd4 || a_res_id !== 16'h3) begin
        n_fail++; $display("FAIL bp_hold cyc %0d: got v=%b rdy=%b iv=%b t=%h id=%h exp 1 0 0 22222222 3",
                           i, a_res_valid, a_req_ready, a_ivalid, a_res_t, a_res_id);
      end
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if ({a_req_ready, a_res_valid, a_ivalid} !== 3'b100 || a_count !== 32'd3) begin
      n_fail++; $display("FAIL bp_release: got rdy/v/iv=%b cnt=%0d exp 100 3", {a_req_ready, a_res_valid, a_ivalid}, a_count);
    end
    tick();
    a_req_valid = 1'b0;
    n_tests++;
    if ({a_ivalid, a_req_ready} !== 2'b10 || a_ins_tri !== 32'd1) begin
      n_fail++; $display("FAIL bp_next_accept: got iv/rdy=%b tri=%0d exp 10 1", {a_ivalid, a_req_ready}, a_ins_tri);
    end
    a_finish = 1'b1; a_hit_in = 1'b1; a_t_in = 32'sh00000005; a_idx_in = 32'd0;
    tick(); tick(); tick();
    n_tests++;
    if (a_res_valid !== 1'b1 || a_res_id !== 16'h9 || a_res_t !== 32'sh5 || a_res_hit !== 1'b1) begin
      n_fail++; $display("FAIL bp_second_result: got v=%b id=%h t=%h hit=%b exp 1 9 5 1", a_res_valid, a_res_id, a_res_t, a_res_hit);
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if (a_count !== 32'd4) begin n_fail++; $display("FAIL bp_count: got %0d exp 4", a_count); end
  endtask

  task automatic test_reset_mid_wait();
    a_req_id = 16'h0011; a_req_tri = 32'd2; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0; a_finish = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    a_reset = 1'b1;
    tick();
    n_tests++;
    if ({a_busy, a_res_valid, a_ivalid, a_req_ready} !== 4'b0001 || a_count !== 32'd0) begin
      n_fail++; $display("FAIL midwait_reset: got busy/v/iv/rdy=%b cnt=%0d exp 0001 0",
                         {a_busy, a_res_valid, a_ivalid, a_req_ready}, a_count);
    end
    a_reset = 1'b0; a_finish = 1'b1;
    a_req_id = 16'h0022; a_req_tri = 32'd0; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    n_tests++;
    if (a_res_valid !== 1'b1 || a_res_id !== 16'h22) begin
      n_fail++; $display("FAIL midwait_next: got v=%b id=%h exp 1 22", a_res_valid, a_res_id);
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if (a_count !== 32'd1) begin n_fail++; $display("FAIL midwait_count: got %0d exp 1", a_count); end
  endtask

  task automatic test_timeout();
    int early_err;
    int bad;
    b_req_id = 16'h0001; b_req_tri = 32'd1; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0; b_finish = 1'b0;
    tick(); tick();
    early_err = 0;
    for (int w = 1; w <= 8; w++) begin
      if (b_error) early_err++;
      tick();
    end
    n_tests++;
    if (early_err !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d error cycles exp 0", early_err); end
    n_tests++;
    if ({b_error, b_req_ready, b_res_valid, b_ivalid, b_busy} !== 5'b10001) begin
      n_fail++; $display("FAIL timeout_error: got err/rdy/v/iv/busy=%b exp 10001", {b_error, b_req_ready, b_res_valid, b_ivalid, b_busy});
    end
    b_req_valid = 1'b1; b_finish = 1'b1; b_res_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({b_error, b_req_ready, b_res_valid, b_ivalid} !== 4'b1000) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL timeout_sticky: got %0d bad cycles exp 0", bad); end
    b_req_valid = 1'b0; b_res_ready = 1'b0; b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    n_tests++;
    if ({b_error, b_req_ready, b_res_valid, b_ivalid, b_busy, b_res_hit} !== 6'b010000 ||
        b_count !== 32'd0 || b_res_t !== 32'sh0 || b_res_idx !== 32'd0 || b_res_id !== 16'd0 ||
        b_ins_tri !== 32'd0 || b_ins_base !== 32'd0 || b_ins_ray !== 192'd0) begin
      n_fail++; $display("FAIL timeout_reset: got err/rdy/v/iv/busy/hit=%b cnt=%0d tri=%0d exp 010000 0 0",
                         {b_error, b_req_ready, b_res_valid, b_ivalid, b_busy, b_res_hit}, b_count, b_ins_tri);
    end
  endtask

  task automatic test_finish_wins();
    b_req_id = 16'h0002; b_req_tri = 32'd4; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0; b_finish = 1'b0;
    tick(); tick();
    for (int w = 1; w <= 7; w++) tick();
    b_finish = 1'b1; b_hit_in = 1'b1; b_t_in = 32'sh00000077; b_idx_in = 32'd6;
    tick();
    n_tests++;
    if ({b_res_valid, b_error} !== 2'b10 || b_res_t !== 32'sh77 || b_res_idx !== 32'd6) begin
      n_fail++; $display("FAIL finish_wins: got v/err=%b t=%h idx=%0d exp 10 77 6", {b_res_valid, b_error}, b_res_t, b_res_idx);
    end
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    n_tests++;
    if (b_count !== 32'd1 || b_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL finish_wins_done: got cnt=%0d rdy=%b exp 1 1", b_count, b_req_ready);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_req_valid = 1'b0; a_req_ray = '0; a_req_id = '0; a_req_base = '0; a_req_tri = '0;
    a_hit_in = 1'b0; a_t_in = '0; a_idx_in = '0; a_finish = 1'b1; a_res_ready = 1'b0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_ray = RAY1; b_req_id = '0; b_req_base = 32'h2000; b_req_tri = '0;
    b_hit_in = 1'b0; b_t_in = '0; b_idx_in = '0; b_finish = 1'b1; b_res_ready = 1'b0;
    tick();
    tick();
    test_reset();
    a_reset = 1'b0; b_reset = 1'b0;
    tick();
    test_single_ray();
    test_zero_tri();
    test_stale_finish();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    test_finish_wins();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd16777215, meaning max cycles in WAIT before error; 0 disables the watchdog.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port i_req_valid  in  1  ray request valid.
REQ-005 SHALL have port o_req_ready  out  1  dispatcher can accept a request.
REQ-006 SHALL have port i_req_ray  in  192  ray {D.z,D.y,D.x,E.z,E.y,E.x}, 32-bit Q16.16 each, E.x in [31:0].
REQ-007 SHALL have port i_req_id  in  16  requester tag.
REQ-008 SHALL have port i_req_baseaddr  in  32  triangle table base address.
REQ-009 SHALL have port i_req_tri_cnt  in  32  triangle count.
REQ-010 SHALL have ports ins_ivalid out 1, ins_ray out 192, ins_baseaddr out 32, ins_tri_cnt out 32  drive the triangle-intersector start.
REQ-011 SHALL have ports ins_hit in 1, ins_t in 32 (signed), ins_tri_index in 32, ins_finish in 1  intersector results; ins_finish is a level that is 1 when idle.
REQ-012 SHALL have ports o_res_valid out 1, i_res_ready in 1, o_res_id out 16, o_res_hit out 1, o_res_t out 32, o_res_tri_index out 32  result channel.
REQ-013 SHALL have ports o_busy out 1, o_error out 1, o_ray_count out 32  status.

Function
REQ-014 SHALL implement states IDLE, LAUNCH, ARM, WAIT, RESULT, ERROR.
REQ-015 o_req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where i_req_valid && o_req_ready.
REQ-016 On accept, the block SHALL register ray, id, baseaddr and tri_cnt; ins_ray/ins_baseaddr/ins_tri_cnt SHALL come from these registers and hold constant until return to IDLE.
REQ-017 Accept with tri_cnt != 0 SHALL go to LAUNCH; accept with tri_cnt == 0 SHALL go straight to RESULT with hit=0, t=32'sh7fffffff, tri_index=0, without asserting ins_ivalid.
REQ-018 ins_ivalid SHALL be 1 for exactly the single LAUNCH cycle; LAUNCH -> ARM unconditionally.
REQ-019 ARM SHALL last one cycle, ignore ins_finish (stale 1 before intersector clears), then go to WAIT.
REQ-020 In WAIT, ins_finish==1 SHALL capture ins_hit, ins_t, ins_tri_index into result registers and go to RESULT on the next edge.
REQ-021 o_res_valid SHALL be 1 in RESULT only; result fields SHALL be stable while o_res_valid && !i_res_ready.
REQ-022 RESULT with i_res_ready==1 SHALL go to IDLE and increment o_ray_count (32-bit, wraps 0xFFFFFFFF -> 0); no new request is accepted in that same cycle.
REQ-023 A 32-bit watchdog SHALL clear on entering WAIT and count each WAIT cycle; if TIMEOUT_CYCLES!=0 and it reaches TIMEOUT_CYCLES with ins_finish==0, go to ERROR.
REQ-024 If ins_finish rises on the same cycle the watchdog reaches the limit, finish SHALL win (go to RESULT).
REQ-025 ERROR SHALL hold o_error=1, o_req_ready=0, o_res_valid=0, ins_ivalid=0 until reset.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 Minimum latency accept -> o_res_valid SHALL be 4 cycles for tri_cnt!=0 with ins_finish returning 1 on the first WAIT cycle, and 1 cycle for tri_cnt==0.

Reset
REQ-028 On reset: state IDLE, o_req_ready=1 on the following cycle, ins_ivalid=0, o_res_valid=0, o_res_hit=0, o_res_t=0, o_res_tri_index=0, o_res_id=0, o_busy=0, o_error=0, o_ray_count=0, watchdog=0, registered ray/baseaddr/tri_cnt=0.
REQ-029 Reset asserted in any state, including mid-WAIT or ERROR, SHALL override all transitions that cycle; ins_ivalid SHALL be 0 during reset.

Verification
REQ-030 Single ray: id=0x0005, tri_cnt=3, model asserts finish 10 cycles after ins_ivalid with hit=1, t=0x00018000, index=2 -> exactly one ins_ivalid pulse, then o_res_valid with id=5, hit=1, t=0x00018000, index=2; o_ray_count=1.
REQ-031 Zero triangles: tri_cnt=0 -> no ins_ivalid ever, o_res_valid next cycle, hit=0, t=0x7fffffff, index=0.
REQ-032 Stale finish: ins_finish held 1 throughout launch -> result captured no earlier than the first WAIT cycle; hit/t taken from that cycle.
REQ-033 Backpressure: i_res_ready=0 for 20 cycles while i_req_valid=1 -> result fields stable, o_req_ready=0, no second ins_ivalid; on ready, next request accepted one cycle later.
REQ-034 Timeout: TIMEOUT_CYCLES=8, finish never returns -> o_error=1 after the 8th WAIT cycle, o_req_ready stays 0 until reset, then all outputs are back at reset values.
REQ-035 Reset mid-WAIT after 5 cycles -> o_busy=0, o_res_valid=0, o_ray_count unchanged at 0, next request accepted normally.
